// File: rtl/even_sweep_controller.sv
// even_sweep_controller: drives an external even up/down counter through
// load/count/turn-around sweeps. Optional pause input: define SWEEP_PAUSE_EN.
module even_sweep_controller #(
    parameter int TICK_DIV   = 4,
    parameter int MAX_SWEEPS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
`ifdef SWEEP_PAUSE_EN
    input  logic       pause,
`endif
    input  logic [3:0] start_val,
    input  logic [3:0] count_fb,
    output logic       load,
    output logic       count_en,
    output logic [1:0] c,
    output logic [3:0] data_in,
    output logic       busy,
    output logic       sweep_done,
    output logic [3:0] sweeps
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_UP   = 3'd2;
    localparam logic [2:0] S_DOWN = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);

    logic [2:0] state;
    logic [2:0] state_nx;
    logic [7:0] presc;
    logic [7:0] presc_nx;
    logic [3:0] sweeps_nx;
    logic [3:0] sweeps_sat;
    logic [4:0] sweeps_inc;
    logic       pause_i;
    logic       tick;
    logic       last_sweep;

`ifdef SWEEP_PAUSE_EN
    assign pause_i = pause;
`else
    assign pause_i = 1'b0;
`endif

    assign tick       = (presc == TICK_LAST);
    assign sweeps_inc = {1'b0, sweeps} + 5'd1;
    assign sweeps_sat = (sweeps == 4'd15) ? 4'd15 : sweeps_inc[3:0];
    assign last_sweep = (MAX_SWEEPS != 0) && (sweeps_inc == 5'(MAX_SWEEPS));

    // Next-state, prescaler and round-trip counter decisions
    always_comb begin
        state_nx  = state;
        presc_nx  = presc;
        sweeps_nx = sweeps;
        unique case (state)
            S_IDLE: begin
                if (start && !stop) begin
                    state_nx  = S_LOAD;
                    sweeps_nx = 4'd0;
                end
            end
            S_LOAD: begin
                state_nx = stop ? S_IDLE : S_UP;
                presc_nx = 8'd0;
            end
            S_UP: begin
                if (stop) begin
                    state_nx = S_IDLE;
                    presc_nx = 8'd0;
                end else if (!pause_i) begin
                    if (tick) begin
                        presc_nx = 8'd0;
                        if (count_fb == 4'd14)
                            state_nx = S_DOWN;
                    end else begin
                        presc_nx = presc + 8'd1;
                    end
                end
            end
            S_DOWN: begin
                if (stop) begin
                    state_nx = S_IDLE;
                    presc_nx = 8'd0;
                end else if (!pause_i) begin
                    if (tick) begin
                        presc_nx = 8'd0;
                        if (count_fb == 4'd0) begin
                            sweeps_nx = sweeps_sat;
                            state_nx  = last_sweep ? S_DONE : S_UP;
                        end
                    end else begin
                        presc_nx = presc + 8'd1;
                    end
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
                presc_nx = 8'd0;
            end
            default: begin
                state_nx = S_IDLE;
                presc_nx = 8'd0;
            end
        endcase
    end

    // Counter control decode; reset blocks any strobe on the reset edge
    always_comb begin
        load       = 1'b0;
        count_en   = 1'b0;
        c          = 2'b11;
        data_in    = 4'd0;
        busy       = 1'b1;
        sweep_done = 1'b0;
        unique case (state)
            S_IDLE: busy = 1'b0;
            S_LOAD: begin
                load    = !stop;
                data_in = {start_val[3:1], 1'b0};
            end
            S_UP: begin
                c        = 2'b00;
                count_en = tick && !stop && !pause_i
                           && (count_fb != 4'd14);
            end
            S_DOWN: begin
                c        = 2'b01;
                count_en = tick && !stop && !pause_i
                           && (count_fb != 4'd0);
            end
            S_DONE: sweep_done = 1'b1;
            default: busy = 1'b0;
        endcase
        if (reset) begin
            load     = 1'b0;
            count_en = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            presc  <= 8'd0;
            sweeps <= 4'd0;
        end else begin
            state  <= state_nx;
            presc  <= presc_nx;
            sweeps <= sweeps_nx;
        end
    end

endmodule

// File: doc/even_sweep_controller.md
EVEN_SWEEP_CONTROLLER -- requirements
Module: even_sweep_controller

Interface
REQ-001 Parameter TICK_DIV, default 4: cycles per counter step; legal range 2..255.
REQ-002 Parameter MAX_SWEEPS, default 3: full up/down round trips per run; legal range 0..15; 0 means run until stopped.
REQ-003 clk  input  1  posedge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin a run; sampled only in IDLE.
REQ-006 stop  input  1  abort a run; sampled in every state except IDLE.
REQ-007 start_val  input  4  start value for the downstream counter.
REQ-008 count_fb  input  4  current count fed back from the downstream even up/down counter.
REQ-009 load  output  1  parallel-load strobe to the counter.
REQ-010 count_en  output  1  count-enable to the counter.
REQ-011 c  output  2  counter control: 2'b00 = +2, 2'b01 = -2, 2'b11 = hold.
REQ-012 data_in  output  4  parallel load value to the counter.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 sweep_done  output  1  one-cycle pulse on run completion.
REQ-015 sweeps  output  4  completed round trips in the current or last run.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, LOAD, UP, DOWN and DONE.
REQ-017 Outputs SHALL be combinational decodes of state, prescaler and count_fb; the counter consumes them on the same clk edge.
REQ-018 IDLE SHALL drive load=0, count_en=0, c=2'b11 and hold sweeps; start=1 with stop=0 moves to LOAD and clears sweeps.
REQ-019 LOAD SHALL last one cycle with load=1, count_en=0, data_in={start_val[3:1],1'b0}, then move to UP with prescaler=0.
REQ-020 In UP and DOWN, a prescaler SHALL count 0..TICK_DIV-1 and wrap; tick is high when prescaler==TICK_DIV-1.
REQ-021 UP SHALL drive c=2'b00; on tick, if count_fb!=14 then count_en=1, else count_en=0 and the next state is DOWN.
REQ-022 DOWN SHALL drive c=2'b01; on tick, if count_fb!=0 then count_en=1, else count_en=0 and sweeps increments by 1.
REQ-023 On the DOWN turnaround tick, the next state SHALL be DONE if MAX_SWEEPS!=0 and the incremented sweeps equals MAX_SWEEPS; otherwise it SHALL be UP.
REQ-024 sweeps SHALL saturate at 15 when MAX_SWEEPS=0.
REQ-025 The prescaler SHALL reset to 0 on every state change.
REQ-026 DONE SHALL last one cycle with sweep_done=1, count_en=0 and c=2'b11, then move to IDLE.
REQ-027 In LOAD, UP or DOWN, stop=1 SHALL force count_en=0 and load=0 that cycle and move to IDLE; stop takes priority over tick and turnaround.
REQ-028 start=1 and stop=1 together in IDLE SHALL leave the FSM in IDLE.
REQ-029 start SHALL be ignored outside IDLE.
REQ-030 data_in SHALL be 0 in every state except LOAD.
REQ-031 count_en and load SHALL never be high in the same cycle.

Reset
REQ-032 reset=1 at a clk edge SHALL force IDLE, prescaler=0, sweeps=0, load=0, count_en=0, c=2'b11, data_in=0, busy=0 and sweep_done=0, overriding all other inputs.
REQ-033 reset asserted mid-run SHALL abort the run with no further load or count_en pulse after the reset edge.

Configuration
REQ-034 With macro SWEEP_PAUSE_EN defined, an input port pause (1 bit) SHALL exist.
REQ-035 With SWEEP_PAUSE_EN defined, pause=1 in UP or DOWN SHALL freeze the prescaler and state and force count_en=0; stop and reset still take priority over pause.
REQ-036 With SWEEP_PAUSE_EN not defined, the pause port SHALL be absent and behaviour SHALL be as in REQ-016..REQ-031.

Verification (the bench models the downstream counter responding to load, count_en and c)
REQ-037 Reset: reset=1 for 2 cycles with start=1 -> busy=0, c=2'b11, sweeps=0, no load pulse.
REQ-038 Single sweep: TICK_DIV=2, MAX_SWEEPS=1, start_val=5 -> data_in=4 on load; count_fb runs 4,6,...,14 then 12,...,0; exactly one sweep_done pulse; sweeps=1; busy=0 afterwards.
REQ-039 Turnaround: count_fb=14 on an UP tick -> count_en=0 that cycle and c=2'b01 the next cycle; count_fb never wraps to 0 or 2.
REQ-040 Stop: TICK_DIV=4, stop=1 on the same cycle as a tick in DOWN -> count_en=0 that cycle; IDLE next cycle; sweep_done stays 0.
REQ-041 Infinite run: MAX_SWEEPS=0, 20 round trips -> sweeps saturates at 15; no sweep_done pulse until stop, and none after it.
REQ-042 Pause (SWEEP_PAUSE_EN defined): pause=1 for 10 cycles in UP -> count_fb is unchanged and the prescaler resumes from its frozen value when pause returns to 0.
